// File: rtl/shift_add_multiplier_pkg.sv
// Shared ALU package: multiplier state encoding and iteration count.
// Imported by the multiplier control and datapath.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int ITERS = 32;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Adder32Bit: 32-bit ripple-carry adder used by the ALU datapath.
// Ports: A, B (32b addends) -> Sum (32b), Cout (carry out).
module Adder32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum,
  output logic        Cout
);

  logic c;

  always_comb begin
    c   = 1'b0;
    Sum = '0;
    for (int i = 0; i < 32; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 32x32 unsigned shift-add multiplier, one bit per clock.
// Ports: Clk, Rst_n, Start, A, B in; P (64b), Busy, Done out.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               Busy,
  output logic               Done
);

  mul_state_t state, state_n;

  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;
  logic [31:0] sum;
  logic        cout;
  logic        accept;
  logic        last;

  Adder32Bit u_add (
    .A    (hi),
    .B    (mcand),
    .Sum  (sum),
    .Cout (cout)
  );

  assign accept = Start && (state != RUN);
  assign last   = (cnt == 5'(ITERS - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last)   state_n = DONE;
      DONE:    state_n = accept ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Carry-out is the 33rd bit of the partial sum and lands in hi[31].
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= A;
      hi    <= '0;
      lo    <= B;
      cnt   <= '0;
    end else if (state == RUN) begin
      if (lo[0]) {hi, lo} <= {cout, sum, lo[31:1]};
      else       {hi, lo} <= {1'b0, hi, lo[31:1]};
      cnt <= cnt + 5'd1;
    end
  end

  assign P    = {hi, lo};
  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier.
// Checks product, latency, handshake, reset abort and back-to-back start.
module tb_shift_add_multiplier;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] P;
  logic        Busy;
  logic        Done;

  int n_cmp;
  int n_bad;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .P     (P),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands with Start, let one edge sample it, drop Start.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    A     = a;
    B     = b;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Count edges until Done shows up, bounded at 40.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!Done && n < 40);
  endtask

  int n;
  int pulses;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Rst_n = 1'b0;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    #2;
    check("rst_p", P, 64'h0);
    check("rst_busy", {63'b0, Busy}, 64'd0);
    check("rst_done", {63'b0, Done}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // 3 x 5
    start_op(32'd3, 32'd5);
    check("busy_after_t0", {63'b0, Busy}, 64'd1);
    wait_done(n);
    check("lat_3x5", 64'(n), 64'd32);
    check("p_3x5", P, 64'h0000_0000_0000_000F);
    check("busy_at_done", {63'b0, Busy}, 64'd0);
    @(posedge Clk);
    #1;
    check("done_one_cycle", {63'b0, Done}, 64'd0);
    check("p_hold", P, 64'h0000_0000_0000_000F);

    // all ones: carry into hi every iteration
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    check("lat_ff", 64'(n), 64'd32);
    check("p_ff", P, 64'hFFFF_FFFE_0000_0001);
    @(posedge Clk);
    #1;

    // zero multiplier still runs full length
    start_op(32'h1234_5678, 32'd0);
    wait_done(n);
    check("lat_zero", 64'(n), 64'd32);
    check("p_zero", P, 64'h0);
    @(posedge Clk);
    #1;
    check("zero_done_once", {63'b0, Done}, 64'd0);

    // Start during RUN is ignored
    start_op(32'd7, 32'd6);
    repeat (4) begin
      @(posedge Clk);
      #1;
    end
    A     = 32'hFFFF_FFFF;
    B     = 32'hFFFF_FFFF;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_done(n);
    check("lat_midstart", 64'(n + 5), 64'd32);
    check("p_midstart", P, 64'h2A);
    @(posedge Clk);
    #1;

    // asynchronous reset aborts a run
    start_op(32'd2, 32'd2);
    repeat (9) begin
      @(posedge Clk);
      #1;
    end
    check("busy_pre_rst", {63'b0, Busy}, 64'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_p", P, 64'h0);
    check("arst_busy", {63'b0, Busy}, 64'd0);
    check("arst_done", {63'b0, Done}, 64'd0);
    @(negedge Clk);
    Rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done) pulses++;
    end
    check("no_done_after_rst", 64'(pulses), 64'd0);
    check("idle_after_rst", {63'b0, Busy}, 64'd0);
    start_op(32'd4, 32'd4);
    wait_done(n);
    check("lat_4x4", 64'(n), 64'd32);
    check("p_4x4", P, 64'h10);
    @(posedge Clk);
    #1;

    // back-to-back: Start held during the DONE cycle
    start_op(32'd9, 32'd9);
    wait_done(n);
    check("lat_9x9", 64'(n), 64'd32);
    check("p_9x9", P, 64'h51);
    A     = 32'd10;
    B     = 32'd10;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("b2b_done_drop", {63'b0, Done}, 64'd0);
    check("b2b_busy", {63'b0, Busy}, 64'd1);
    wait_done(n);
    check("lat_10x10", 64'(n), 64'd32);
    check("p_10x10", P, 64'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
